// File: rtl/core_ctrl_pkg.sv
// rtl/core_ctrl_pkg.sv - shared state, opcode and select encodings for the multi-cycle core controller
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEM       = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_REG      = 7'b0110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_TGT = 1'b1;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_PC  = 2'b01;
  localparam logic [1:0] RES_MEM = 2'b10;

  function automatic logic is_rv32i(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_MISC_MEM, OP_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - counts stalled memory-wait cycles and flags expiry on the TIMEOUT-th one
module bus_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] count;

  // Expiry is combinational so a ready arriving in the same cycle still wins.
  assign expired = waiting && (count == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (waiting && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer with halt, bus watchdog and retire counter
module multicycle_controller
  import core_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32,
  parameter int TIMEOUT = 255,
  parameter int TMO_W   = 8
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic [6:0]         in_opcode,
  input  logic               in_reg_write,
  input  logic               in_mem_write,
  input  logic [1:0]         in_choose_result,
  input  logic               in_branch_taken,
  input  logic               in_imem_ready,
  input  logic               in_dmem_ready,
  output logic               out_imem_req,
  output logic               out_dmem_req,
  output logic               out_dmem_we,
  output logic               out_ir_write,
  output logic               out_pc_write,
  output logic               out_pc_src,
  output logic               out_reg_write,
  output logic [2:0]         out_state,
  output logic               out_halted,
  output logic               out_illegal,
  output logic               out_bus_fault,
  output logic [COUNT_W-1:0] out_retired
);

  state_t state, state_next;

  logic imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, reg_write;
  logic retire, set_illegal, set_fault;
  logic waiting, expired;
  logic illegal, bus_fault;
  logic [COUNT_W-1:0] retired;

  // Write-enable and result-select are resolved in the datapath; the sequencer does not need them.
  logic unused_decode;
  assign unused_decode = ^{in_reg_write, in_choose_result};

  assign waiting = ((state == FETCH) && !in_imem_ready) ||
                   ((state == MEM)   && !in_dmem_ready);

  bus_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TMO_W  (TMO_W)
  ) u_watchdog (
    .clk    (in_clk),
    .rst_n  (in_rst_n),
    .waiting(waiting),
    .clear  (!waiting),
    .expired(expired)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_SEQ;
    reg_write   = 1'b0;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (in_imem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_SRC_SEQ;
          state_next = DECODE;
        end else if (expired) begin
          set_fault  = 1'b1;
          state_next = HALT;
        end
      end
      DECODE: begin
        if (in_opcode == OP_SYSTEM) begin
          state_next = HALT;
        end else if (!is_rv32i(in_opcode)) begin
          set_illegal = 1'b1;
          state_next  = HALT;
        end else begin
          state_next = EXECUTE;
        end
      end
      EXECUTE: begin
        case (in_opcode)
          OP_BRANCH: begin
            pc_write   = in_branch_taken;
            pc_src     = PC_SRC_TGT;
            retire     = 1'b1;
            state_next = FETCH;
          end
          OP_JAL, OP_JALR: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_TGT;
            state_next = WRITEBACK;
          end
          OP_LOAD, OP_STORE: state_next = MEM;
          default:           state_next = WRITEBACK;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = in_mem_write;
        if (in_dmem_ready) begin
          if (in_mem_write) begin
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WRITEBACK;
          end
        end else if (expired) begin
          set_fault  = 1'b1;
          state_next = HALT;
        end
      end
      WRITEBACK: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Cause flags are sticky; only one can ever be set because HALT is entered once per reset.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      illegal   <= 1'b0;
      bus_fault <= 1'b0;
      retired   <= '0;
    end else begin
      if (set_illegal) illegal <= 1'b1;
      if (set_fault) bus_fault <= 1'b1;
      if (retire) retired <= retired + 1'b1;
    end
  end

  // Strobes are masked by reset so an in-flight request drops without waiting for a clock edge.
  assign out_imem_req  = imem_req  & in_rst_n;
  assign out_dmem_req  = dmem_req  & in_rst_n;
  assign out_dmem_we   = dmem_we   & in_rst_n;
  assign out_ir_write  = ir_write  & in_rst_n;
  assign out_pc_write  = pc_write  & in_rst_n;
  assign out_pc_src    = pc_src    & in_rst_n;
  assign out_reg_write = reg_write & in_rst_n;
  assign out_state     = state;
  assign out_halted    = (state == HALT);
  assign out_illegal   = illegal;
  assign out_bus_fault = bus_fault;
  assign out_retired   = retired;

endmodule
